// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core's load/store stage and the data memory responder.
// Signal names keep the responder's point of view (_i into the responder, _o out of it).
interface data_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with RV32I load/store decoding, fixed response
// latency and a valid/ready request/response handshake.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [7:0]            mem [Depth];

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_we;
  logic [2:0]            acc_funct3;
  logic [ADDR_WIDTH-1:0] acc_addr, acc_addr1, acc_addr2, acc_addr3;
  logic [31:0]           acc_wdata;
  logic                  acc_err;
  logic [31:0]           load_data;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr_i[31:ADDR_WIDTH];

  assign bus.req_ready_o = (state_q == StIdle) && rst_ni;
  assign bus.rsp_valid_o = (state_q == StResp);
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

  assign accept     = bus.req_valid_i && bus.req_ready_o;
  assign enter_resp = ((state_q == StIdle) && accept && (LATENCY == 1)) ||
                      ((state_q == StWait) && (cnt_q == 4'd1));

  // With LATENCY = 1 the access completes on the acceptance edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we     = bus.req_we_i;
      acc_funct3 = bus.req_funct3_i;
      acc_addr   = bus.req_addr_i[ADDR_WIDTH-1:0];
      acc_wdata  = bus.req_wdata_i;
    end else begin
      acc_we     = we_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
    acc_addr1 = acc_addr + ADDR_WIDTH'(1);
    acc_addr2 = acc_addr + ADDR_WIDTH'(2);
    acc_addr3 = acc_addr + ADDR_WIDTH'(3);
  end

  always_comb begin
    acc_err = 1'b0;
    unique case (acc_funct3)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = acc_addr[0];
      3'b010:  acc_err = |acc_addr[1:0];
      3'b100:  acc_err = acc_we;
      3'b101:  acc_err = acc_we | acc_addr[0];
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    unique case (acc_funct3)
      3'b000:  load_data = {{24{mem[acc_addr][7]}}, mem[acc_addr]};
      3'b001:  load_data = {{16{mem[acc_addr1][7]}}, mem[acc_addr1], mem[acc_addr]};
      3'b010:  load_data = {mem[acc_addr3], mem[acc_addr2], mem[acc_addr1], mem[acc_addr]};
      3'b100:  load_data = {24'h0, mem[acc_addr]};
      3'b101:  load_data = {16'h0, mem[acc_addr1], mem[acc_addr]};
      default: load_data = 32'h0;
    endcase
  end

  // Contents survive reset; a reset edge suppresses any commit on that edge.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enter_resp && acc_we && !acc_err) begin
      mem[acc_addr] <= acc_wdata[7:0];
      if (acc_funct3 != 3'b000) begin
        mem[acc_addr1] <= acc_wdata[15:8];
      end
      if (acc_funct3 == 3'b010) begin
        mem[acc_addr2] <= acc_wdata[23:16];
        mem[acc_addr3] <= acc_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q     <= bus.req_we_i;
            funct3_q <= bus.req_funct3_i;
            addr_q   <= bus.req_addr_i[ADDR_WIDTH-1:0];
            wdata_q  <= bus.req_wdata_i;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'h0 : load_data;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Exercises three responders (LATENCY 1, 2, 3) with directed tables, hand-written corner
// sequences and randomized traffic checked against a byte-array memory model.
module tb_data_mem_responder;
  localparam int N = 3;  // instance d has LATENCY d+1

  logic                clk;
  int                  cyc;
  logic [N-1:0]        rst_n;
  logic [N-1:0]        req_valid, req_we, rsp_ready;
  logic [N-1:0][2:0]   funct3;
  logic [N-1:0][31:0]  addr, wdata;
  wire  [N-1:0]        req_ready, rsp_valid, rsp_err, busy;
  wire  [N-1:0][31:0]  rdata;

  int checks;
  int failures;

  logic [7:0] mm [N][4096];

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_responder_if bus ();
    assign bus.req_valid_i  = req_valid[g];
    assign bus.req_we_i     = req_we[g];
    assign bus.req_funct3_i = funct3[g];
    assign bus.req_addr_i   = addr[g];
    assign bus.req_wdata_i  = wdata[g];
    assign bus.rsp_ready_i  = rsp_ready[g];
    assign req_ready[g]     = bus.req_ready_o;
    assign rsp_valid[g]     = bus.rsp_valid_o;
    assign rsp_err[g]       = bus.rsp_err_o;
    assign busy[g]          = bus.busy_o;
    assign rdata[g]         = bus.rsp_rdata_o;

    data_mem_responder #(.ADDR_WIDTH(12), .LATENCY(g + 1)) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n[g]),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, sign extension by masking.
  function automatic void model(input int d, input bit we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int size;
    int base;
    logic [31:0] v;
    size = 1 << f3[1:0];
    if (we) er = (f3 > 3'd2);
    else    er = (f3[1:0] == 2'd3) || (f3 == 3'b110);
    if (!er && (a % size) != 0) er = 1'b1;
    rd = 32'h0;
    base = int'(a % 4096);
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) mm[d][(base + i) % 4096] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mm[d][(base + i) % 4096]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endfunction

  // Presents one request, waits for the response and consumes it (rsp_ready held high).
  task automatic txn(input int d, input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat, output int pc);
    int n;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    funct3[d]    = f3;
    addr[d]      = a;
    wdata[d]     = wd;
    rsp_ready[d] = 1'b1;
    pc  = cyc;
    lat = 0;
    do begin
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      lat++;
    end while (!rsp_valid[d] && lat < 40);
    rd = rdata[d];
    er = rsp_err[d];
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat, pc, prev_pc;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    checks = 0;
    failures = 0;
    rst_n = '0;
    req_valid = '0;
    req_we = '0;
    funct3 = '0;
    addr = '0;
    wdata = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'd0);
      chk($sformatf("rst_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(rsp_err[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
    end
    rst_n = '1;
    #1;
    for (int d = 0; d < N; d++) chk($sformatf("post_rst_ready%0d", d), 32'(req_ready[d]), 32'd1);

    // Directed vectors on the LATENCY = 2 instance.
    tbl.push_back('{1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 3'b000, 32'h101,  32'h80,       32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'b000, 32'h101,  32'h0,        32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 3'b100, 32'h101,  32'h0,        32'h00000080, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEAD80EF, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 32'h103,  32'h5555,     32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'b010, 32'h102,  32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEAD80EF, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 32'h100,  32'h0,        32'hFFFF80EF, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 32'h102,  32'h0,        32'h0000DEAD, 1'b0});
    tbl.push_back('{1'b0, 3'b011, 32'h100,  32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 3'b100, 32'h100,  32'h11,       32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'b010, 32'h1100, 32'h0,        32'hDEAD80EF, 1'b0});
    foreach (tbl[i]) begin
      txn(1, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er, lat, pc);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
    end

    // Response held for 5 cycles; a store pulsed meanwhile must be dropped.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    funct3[1]    = 3'b010;
    addr[1]      = 32'h100;
    rsp_ready[1] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      lat++;
    end while (!rsp_valid[1] && lat < 40);
    chk("hold_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        addr[1]      = 32'h100;
        wdata[1]     = 32'h0BAD0BAD;
      end
      if (k == 2) req_valid[1] = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", k), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("hold%0d_rdata", k), rdata[1], 32'hDEAD80EF);
      chk($sformatf("hold%0d_err", k), 32'(rsp_err[1]), 32'd0);
      chk($sformatf("hold%0d_ready", k), 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", 32'(rsp_valid[1]), 32'd0);
    chk("hold_release_busy", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;
    chk("hold_not_queued", 32'(busy[1]), 32'd0);
    txn(1, 1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, pc);
    chk("hold_after_rdata", rd, 32'hDEAD80EF);

    // Reset during WAIT aborts an uncommitted store (LATENCY = 3).
    txn(2, 1'b1, 3'b010, 32'h200, 32'hA5A55A5A, rd, er, lat, pc);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    funct3[2]    = 3'b010;
    addr[2]      = 32'h200;
    wdata[2]     = 32'h12345678;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    chk("abort_busy_before", 32'(busy[2]), 32'd1);
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 32'(req_ready[2]), 32'd0);
    chk("abort_valid", 32'(rsp_valid[2]), 32'd0);
    chk("abort_busy", 32'(busy[2]), 32'd0);
    chk("abort_err", 32'(rsp_err[2]), 32'd0);
    chk("abort_rdata", rdata[2], 32'd0);
    rst_n[2] = 1'b1;
    #1;
    chk("abort_release_ready", 32'(req_ready[2]), 32'd1);
    txn(2, 1'b0, 3'b010, 32'h200, 32'h0, rd, er, lat, pc);
    chk("abort_prior_contents", rd, 32'hA5A55A5A);

    // LATENCY = 1: address wrap aliasing.
    txn(0, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, rd, er, lat, pc);
    txn(0, 1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, pc);
    chk("wrap_rdata", rd, 32'hCAFEF00D);
    chk("wrap_lat", 32'(lat), 32'd1);

    // Randomized back-to-back traffic on every instance against the model.
    for (int d = 0; d < N; d++) begin
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        a  = 32'h300 + 32'(4 * w);
        model(d, 1'b1, 3'b010, a, wd, exp_rd, exp_er);
        txn(d, 1'b1, 3'b010, a, wd, rd, er, lat, pc);
      end
      prev_pc = 0;
      for (int i = 0; i < 40; i++) begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        a  = ($urandom & 32'hFFFF_F000) | (32'h300 + 32'($urandom_range(0, 63)));
        wd = $urandom;
        model(d, we, f3, a, wd, exp_rd, exp_er);
        txn(d, we, f3, a, wd, rd, er, lat, pc);
        chk($sformatf("rnd%0d_%0d_rdata", d, i), rd, exp_rd);
        chk($sformatf("rnd%0d_%0d_err", d, i), 32'(er), 32'(exp_er));
        chk($sformatf("rnd%0d_%0d_lat", d, i), 32'(lat), 32'(d + 1));
        if (i > 0) chk($sformatf("rnd%0d_%0d_gap", d, i), 32'(pc - prev_pc), 32'(d + 2));
        prev_pc = pc;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 12, which is the number of byte-address bits decoded; the memory holds 2**ADDR_WIDTH bytes.
REQ-002 The block SHALL take parameter LATENCY, default 2, which is the cycles from request acceptance to rsp_valid_o; legal range 1..15.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid_i, input, 1 bit: the core presents a load/store request.
REQ-006 The block SHALL have port req_ready_o, output, 1 bit: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we_i, input, 1 bit: 1 = store (MemWrite), 0 = load.
REQ-008 The block SHALL have port req_funct3_i, input, 3 bits: access size and sign, using RV32I load/store funct3 encoding.
REQ-009 The block SHALL have port req_addr_i, input, 32 bits: byte address (ALU result).
REQ-010 The block SHALL have port req_wdata_i, input, 32 bits: store data (rs2), aligned to the LSB.
REQ-011 The block SHALL have port rsp_valid_o, output, 1 bit: a response is available.
REQ-012 The block SHALL have port rsp_ready_i, input, 1 bit: the core consumes the response.
REQ-013 The block SHALL have port rsp_rdata_o, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err_o, output, 1 bit: misaligned access or illegal funct3; valid only while rsp_valid_o is high.
REQ-015 The block SHALL have port busy_o, output, 1 bit: a transaction is in flight; the core uses it as a stall.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 The block SHALL drive req_ready_o = 1 only in IDLE, and busy_o = 1 in WAIT and RESP.
REQ-018 The block SHALL accept a request on a clock edge where req_valid_i && req_ready_o, capturing we, funct3, addr[ADDR_WIDTH-1:0] and wdata.
REQ-019 On acceptance, the block SHALL go to RESP if LATENCY = 1; otherwise it SHALL go to WAIT and load a 4-bit down-counter with LATENCY-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-021 rsp_valid_o SHALL first be high exactly LATENCY cycles after the acceptance edge.
REQ-022 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL stay stable until rsp_ready_i = 1; that edge SHALL return the FSM to IDLE.
REQ-023 There SHALL be no combinational path from rsp_ready_i to req_ready_o; a new request is accepted at the earliest one cycle after the response is consumed.
REQ-024 Memory SHALL be little-endian, and address bits above ADDR_WIDTH-1 SHALL be ignored (address wraps).
REQ-025 Stores SHALL use funct3 000 SB (byte wdata[7:0]), 001 SH (wdata[15:0]) and 010 SW (wdata[31:0]); only the addressed bytes SHALL change.
REQ-026 The store SHALL be committed on the edge entering RESP.
REQ-027 Loads SHALL use funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend to 32 bits.
REQ-028 Load data SHALL be sampled on the edge entering RESP, and SHALL include any store committed by an earlier transaction.
REQ-029 An access SHALL be an error if: the halfword address has addr[0] = 1; the word address has addr[1:0] != 00; or funct3 is illegal for the direction (store 011..111, load 011/110/111).
REQ-030 On an error, memory SHALL NOT change, rsp_err_o SHALL be 1, rsp_rdata_o SHALL be 0, and timing SHALL be unchanged.
REQ-031 Stores SHALL produce a response (acknowledge) with rsp_rdata_o = 0.
REQ-032 req_valid_i asserted while busy_o = 1 SHALL be ignored and not queued; the core holds it until it is accepted.

Reset
REQ-033 When rst_ni = 0 at a clock edge, the FSM SHALL go to IDLE and the counter to 0, and rsp_valid_o, rsp_err_o, rsp_rdata_o and busy_o SHALL be 0.
REQ-034 req_ready_o SHALL be 0 while rst_ni = 0 and 1 in the first cycle after release.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 A reset in WAIT SHALL abort the transaction; a store not yet committed SHALL NOT modify memory.
REQ-037 A reset in RESP SHALL drop the pending response.

Verification
REQ-038 The bench SHALL cover: with LATENCY = 2, SW 0xDEADBEEF to 0x100, then LW from 0x100 -> rsp_valid_o exactly 2 cycles after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-039 The bench SHALL cover: SB 0x80 to 0x101, then LB 0x101 -> 0xFFFFFF80; LBU 0x101 -> 0x00000080; LW 0x100 -> 0xDEAD80EF.
REQ-040 The bench SHALL cover: SH to 0x103 and LW from 0x102 -> rsp_err_o = 1, rdata 0, and a following LW 0x100 still returns 0xDEAD80EF.
REQ-041 The bench SHALL cover: rsp_ready_i held low for 5 cycles in RESP -> rsp_valid_o and data held stable, req_ready_o 0 throughout, and a req_valid_i pulse during that time ignored.
REQ-042 The bench SHALL cover: SW 0x12345678 to 0x200 with rst_ni pulled low one cycle after acceptance (LATENCY = 3) -> all outputs 0 next cycle, and after release LW 0x200 returns the prior contents, not 0x12345678.
REQ-043 The bench SHALL cover: LATENCY = 1 with back-to-back requests and rsp_ready_i tied 1 -> one transaction every 2 cycles, and address 0x1000 + ADDR_WIDTH wrap aliases address 0x000.
